// File: rtl/bht_ghr_ctrl.sv
// Global-history (gshare) index generator and in-order in-flight branch tracker feeding the bht.
// Latency: index/prediction combinational in request cycle; GHR and queue update at next posedge.
// Backpressure: pred_ready drops when the queue is full or a mispredict repairs the GHR this cycle.
module bht_ghr_ctrl #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pred_req,
  input  logic [31:0]                pred_pc,
  output logic                       pred_ready,
  output logic                       bht_read,
  output logic [WIDTH-1:0]           bht_r_idx,
  input  logic                       bht_prediction,
  output logic                       pred_taken,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       res_mispredict,
  output logic                       bht_load,
  output logic [WIDTH-1:0]           bht_w_idx,
  output logic                       bht_taken,
  output logic                       bht_correct,
  output logic [$clog2(DEPTH):0]     inflight_cnt,
  output logic [WIDTH-1:0]           ghr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] idx;
    logic             pred;
    logic [WIDTH-1:0] snap;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ghr_q, ghr_d;

  entry_t           head;
  entry_t           push_ent;
  logic             resolve;
  logic             push;
  logic             unused_bits;

  // PC bits outside the index field and the oldest snapshot bit never reach any output.
  assign unused_bits = ^{pred_pc[31:WIDTH+2], pred_pc[1:0], head.snap[WIDTH-1]};

  // Read side, resolve side and handshake; all combinational from current state.
  always_comb begin
    head           = mem_q[rd_ptr_q];
    bht_read       = pred_req;
    bht_r_idx      = pred_pc[WIDTH+1:2] ^ ghr_q;
    pred_taken     = bht_prediction;
    resolve        = res_valid && (cnt_q != '0);
    res_mispredict = resolve && (head.pred != res_taken);
    bht_load       = resolve;
    bht_w_idx      = '0;
    bht_taken      = 1'b0;
    bht_correct    = 1'b0;
    if (resolve) begin
      bht_w_idx   = head.idx;
      bht_taken   = head.pred;
      bht_correct = (head.pred == res_taken);
    end
    // A full queue refuses even if a pop happens this cycle; keeps the ready path short.
    pred_ready     = pred_req && (cnt_q < CW'(DEPTH)) && !res_mispredict;
    push           = pred_ready;
    push_ent       = '{idx: bht_r_idx, pred: bht_prediction, snap: ghr_q};
    inflight_cnt   = cnt_q;
    ghr            = ghr_q;
  end

  // Next-state: mispredict flushes younger entries and rebuilds the GHR from the head snapshot.
  always_comb begin
    ghr_d    = ghr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (res_mispredict) begin
      ghr_d    = {head.snap[WIDTH-2:0], res_taken};
      rd_ptr_d = rd_ptr_q + PW'(1);
      wr_ptr_d = rd_ptr_q + PW'(1);
      cnt_d    = '0;
    end else begin
      if (push) begin
        ghr_d    = {ghr_q[WIDTH-2:0], bht_prediction};
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (resolve) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(resolve);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      ghr_q    <= ghr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Queue storage; contents are qualified by the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_ent;
    end
  end

endmodule
